// File: rtl/vreg_pkg.sv
// ---------------------------------------------------------------------------
// vreg_pkg : default geometry and address-width helper for the vector RF
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vreg_pkg;

  localparam int DEF_ELEMENT_SIZE = 8;
  localparam int DEF_VECTOR_SIZE  = 8;
  localparam int DEF_VECTORS      = 8;

  // Address width for a register count; decode-stage users size their fields with this.
  function automatic int vreg_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vreg_scoreboard.sv
// ---------------------------------------------------------------------------
// vreg_scoreboard : per-register busy bits with operand hazard and conflict flags
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vreg_scoreboard
  import vreg_pkg::*;
#(
  parameter int vectors = DEF_VECTORS,
  parameter int AW      = vreg_aw(DEF_VECTORS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     voper1,
  input  logic [AW-1:0]     voper2,
  input  logic              rsvEnable,
  input  logic [AW-1:0]     rsvAddr,
  input  logic              wEnable,
  input  logic              wCommit,
  input  logic [AW-1:0]     vresult,
  output logic              oper1Busy,
  output logic              oper2Busy,
  output logic              rsvConflict,
  output logic [vectors-1:0] busyVec
);

  logic [vectors-1:0] busy_q;
  logic [vectors-1:0] busy_d;
  logic [vectors-1:0] commit_vec;
  logic [vectors-1:0] rsv_vec;

  always_comb begin
    commit_vec = '0;
    rsv_vec    = '0;
    for (int r = 0; r < vectors; r++) begin
      commit_vec[r] = wEnable && wCommit && (vresult == AW'(r));
      rsv_vec[r]    = rsvEnable && (rsvAddr == AW'(r));
    end
    // Reserve is OR'd in last so a new producer wins over a same-cycle commit.
    busy_d = (busy_q & ~commit_vec) | rsv_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign oper1Busy   = busy_q[voper1] & ~commit_vec[voper1];
  assign oper2Busy   = busy_q[voper2] & ~commit_vec[voper2];
  assign rsvConflict = rsvEnable & busy_q[rsvAddr] & ~commit_vec[rsvAddr];
  assign busyVec     = busy_q;

endmodule

`default_nettype wire

// File: rtl/vreg_file_sb.sv
// ---------------------------------------------------------------------------
// vreg_file_sb : masked/splat vector register file with bypass and scoreboard
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vreg_file_sb
  import vreg_pkg::*;
#(
  parameter  int elementSize = DEF_ELEMENT_SIZE,
  parameter  int vectorSize  = DEF_VECTOR_SIZE,
  parameter  int vectors     = DEF_VECTORS,
  localparam int AW          = vreg_aw(vectors),
  localparam int VW          = elementSize * vectorSize
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         voper1,
  input  logic [AW-1:0]         voper2,
  output logic [VW-1:0]         oper1,
  output logic [VW-1:0]         oper2,
  output logic                  oper1Busy,
  output logic                  oper2Busy,
  input  logic                  rsvEnable,
  input  logic [AW-1:0]         rsvAddr,
  output logic                  rsvConflict,
  input  logic                  wEnable,
  input  logic [AW-1:0]         vresult,
  input  logic [vectorSize-1:0] wMask,
  input  logic                  wSplat,
  input  logic                  wCommit,
  input  logic [VW-1:0]         dataIn,
  output logic [vectors-1:0]    busyVec
);

  logic [VW-1:0] matrix_q [vectors];
  logic [VW-1:0] matrix_d [vectors];
  logic [VW-1:0] eff_data;
  logic [VW-1:0] bit_mask;
  logic [VW-1:0] merged;

  for (genvar i = 0; i < vectorSize; i++) begin : g_elem
    assign eff_data[i*elementSize +: elementSize] =
      wSplat ? dataIn[elementSize-1:0] : dataIn[i*elementSize +: elementSize];
    assign bit_mask[i*elementSize +: elementSize] = {elementSize{wMask[i]}};
  end

  // Post-write image of the addressed register; shared by the array update and the bypass.
  assign merged = (matrix_q[vresult] & ~bit_mask) | (eff_data & bit_mask);

  always_comb begin
    for (int r = 0; r < vectors; r++) begin
      matrix_d[r] = matrix_q[r];
    end
    if (wEnable) begin
      matrix_d[vresult] = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < vectors; r++) begin
        matrix_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < vectors; r++) begin
        matrix_q[r] <= matrix_d[r];
      end
    end
  end

  assign oper1 = (wEnable && (vresult == voper1)) ? merged : matrix_q[voper1];
  assign oper2 = (wEnable && (vresult == voper2)) ? merged : matrix_q[voper2];

  vreg_scoreboard #(
    .vectors (vectors),
    .AW      (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .voper1      (voper1),
    .voper2      (voper2),
    .rsvEnable   (rsvEnable),
    .rsvAddr     (rsvAddr),
    .wEnable     (wEnable),
    .wCommit     (wCommit),
    .vresult     (vresult),
    .oper1Busy   (oper1Busy),
    .oper2Busy   (oper2Busy),
    .rsvConflict (rsvConflict),
    .busyVec     (busyVec)
  );

endmodule

`default_nettype wire

// File: doc/vreg_file_sb.md
# vreg_file_sb

Parametrised vector register file with per-element write masking, scalar-splat writes, write-to-read bypass, and a per-register busy scoreboard. It replaces the fixed 4-entry vector register file in the vector datapath. The decode stage reserves destinations and reads operands, and the execute/writeback stage commits results. It gives decode the hazard information it needs to stall.

## Interface
Parameters:
- elementSize, 8, bits per vector element
- vectorSize, 8, elements per vector register
- vectors, 8, number of vector registers (power of two, ≥2)
- derived: AW = $clog2(vectors); VW = elementSize*vectorSize

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- voper1, voper2  in  AW  read addresses
- oper1, oper2  out  VW  read data (combinational, bypassed)
- oper1Busy, oper2Busy  out  1  operand's register is reserved and not committing this cycle
- rsvEnable  in  1  reserve a destination register
- rsvAddr  in  AW  register to reserve
- rsvConflict  out  1  rsvEnable to an already-busy register not committing this cycle
- wEnable  in  1  write strobe
- vresult  in  AW  write address
- wMask  in  vectorSize  per-element write enable; bit i selects element i (bits [i*elementSize +: elementSize])
- wSplat  in  1  replicate element 0 of dataIn into every masked element
- wCommit  in  1  with wEnable: clear the busy bit of vresult
- dataIn  in  VW  write data
- busyVec  out  vectors  current busy bits (registered)

## Operation
- Storage: vectors × VW flops. No register is hardwired to zero.
- Effective write data: if wSplat, every element = dataIn[elementSize-1:0]; otherwise dataIn.
- Write: on a rising edge with wEnable, element i of matrix[vresult] takes the effective data where wMask[i]=1. Unmasked elements hold. wMask=0 with wEnable is legal: there is no data change, and commit still applies.
- Read: oper1 = matrix[voper1], with bypass. If wEnable and vresult==voper1 in the same cycle, masked elements come from the effective write data and unmasked elements from the array. The same applies to oper2. Both ports may address the same register.
- Scoreboard next-state, per register r:
  - set if rsvEnable and rsvAddr==r;
  - else clear if wEnable, wCommit and vresult==r;
  - else hold.
  - Reserve and commit to the same register in one cycle: busy stays 1, since the new producer wins.
- operNBusy = busy[voperN] and not (wEnable and wCommit and vresult==voperN). A same-cycle reserve does not affect operNBusy.
- rsvConflict = rsvEnable and busy[rsvAddr] and not (same-cycle commit to rsvAddr). The reserve still takes effect. The flag is advisory, for decode/assertions.
- A write without wCommit, or to a non-busy register, is legal and does not touch the scoreboard. This covers partial-result writes.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, busyVec 0. Combinational outputs follow: oper1/oper2 = 0 unless bypassed, busy flags 0, rsvConflict 0.
- Write latency: data is visible through the bypass in the same cycle and from the array from the next cycle.
- Reserve latency: busy is visible on busyVec and operNBusy from the next cycle.
- Commit latency: busy clears combinationally on operNBusy in the commit cycle and on busyVec from the next cycle.
- Reset asserted mid-operation discards any in-flight write or reserve. The first edge after rst_n deasserts is a normal cycle.
- Read addresses and the write port have no handshake. Stalling is the consumer's responsibility, using operNBusy.

## Structure
- Package vreg_pkg holds the default elementSize/vectorSize/vectors localparams, and an AW helper function for decode-stage users.
- Sub-module vreg_scoreboard contains the busy vector, next-state logic, operNBusy and rsvConflict.
- The top level contains the storage, mask/splat merge and bypass muxes.

## Test plan
All scenarios use default parameters.
- Reset, then read all registers: every oper = 64'h0 and busyVec = 8'h00.
- Write v3 with dataIn=64'h1122334455667788, wMask=8'hFF. Then write v3 with wMask=8'h0F, dataIn=64'hAAAAAAAAAAAAAAAA. Read v3 → 64'h11223344AAAAAAAA.
- Splat write v5 with dataIn[7:0]=8'h5C, wMask=8'hF0, and voper1=5 in the same cycle. oper1 = 64'h5C5C5C5C00000000 in that cycle and in the next cycle.
- Reserve v2, then read voper1=2: oper1Busy=1 for 3 cycles. Commit v2 with data 64'h42: oper1Busy=0 and oper1=64'h42 in the commit cycle, and busyVec[2]=0 the next cycle.
- Reserve v6 while committing v6 in the same cycle: busyVec[6]=1 next cycle and rsvConflict=0. A second reserve of v6 gives rsvConflict=1.
- With v1 busy and holding 64'hFF, assert rst_n low between edges: busyVec=0 and v1=0 immediately, without waiting for a clock edge.
